// File: rtl/generador_inmediato.sv
// Two-stage RV32I/RV64I immediate generator with valid/ready handshake,
// sideband tag, flush and a saturating illegal-instruction counter.
module generador_inmediato #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [31:0]      instruccion_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  inmediato_o,
  output logic [2:0]       formato_o,
  output logic             ilegal_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [CNT_W-1:0] cnt_ilegal_o
);

  localparam logic [2:0] FMT_I   = 3'd0;
  localparam logic [2:0] FMT_S   = 3'd1;
  localparam logic [2:0] FMT_B   = 3'd2;
  localparam logic [2:0] FMT_U   = 3'd3;
  localparam logic [2:0] FMT_J   = 3'd4;
  localparam logic [2:0] FMT_SH  = 3'd5;
  localparam logic [2:0] FMT_R   = 3'd6;
  localparam logic [2:0] FMT_ILL = 3'd7;

  logic             v1_q, v1_d;
  logic [31:0]      instr1_q, instr1_d;
  logic [TAG_W-1:0] tag1_q, tag1_d;
  logic             v2_q, v2_d;
  logic [XLEN-1:0]  imm2_q, imm2_d;
  logic [2:0]       fmt2_q, fmt2_d;
  logic             ileg2_q, ileg2_d;
  logic [TAG_W-1:0] tag2_q, tag2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s2_load, s1_load;
  logic [XLEN-1:0]  dec_imm;
  logic [2:0]       dec_fmt;
  logic             dec_ileg;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             is_shift;

  assign opcode   = instr1_q[6:0];
  assign funct3   = instr1_q[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Decode the instruction held in S1 into a sign/zero-extended immediate.
  always_comb begin
    dec_imm  = '0;
    dec_fmt  = FMT_ILL;
    dec_ileg = 1'b1;
    if (instr1_q[1:0] == 2'b11) begin
      dec_ileg = 1'b0;
      case (opcode)
        7'b0000011, 7'b1100111, 7'b1110011: begin
          dec_imm = XLEN'($signed(instr1_q[31:20]));
          dec_fmt = FMT_I;
        end
        7'b0010011: begin
          if (is_shift) begin
            dec_imm = (XLEN == 64) ? XLEN'(instr1_q[25:20]) : XLEN'(instr1_q[24:20]);
            dec_fmt = FMT_SH;
          end else begin
            dec_imm = XLEN'($signed(instr1_q[31:20]));
            dec_fmt = FMT_I;
          end
        end
        7'b0011011: begin
          // OP-IMM-32 only exists on RV64; shifts there always use a 5-bit shamt
          if (XLEN != 64) begin
            dec_ileg = 1'b1;
          end else if (is_shift) begin
            dec_imm = XLEN'(instr1_q[24:20]);
            dec_fmt = FMT_SH;
          end else begin
            dec_imm = XLEN'($signed(instr1_q[31:20]));
            dec_fmt = FMT_I;
          end
        end
        7'b0100011: begin
          dec_imm = XLEN'($signed({instr1_q[31:25], instr1_q[11:7]}));
          dec_fmt = FMT_S;
        end
        7'b1100011: begin
          dec_imm = XLEN'($signed({instr1_q[31], instr1_q[7], instr1_q[30:25],
                                   instr1_q[11:8], 1'b0}));
          dec_fmt = FMT_B;
        end
        7'b0110111, 7'b0010111: begin
          dec_imm = XLEN'($signed({instr1_q[31:12], 12'h000}));
          dec_fmt = FMT_U;
        end
        7'b1101111: begin
          dec_imm = XLEN'($signed({instr1_q[31], instr1_q[19:12], instr1_q[20],
                                   instr1_q[30:21], 1'b0}));
          dec_fmt = FMT_J;
        end
        7'b0110011, 7'b0111011: begin
          dec_fmt = FMT_R;
        end
        default: begin
          dec_ileg = 1'b1;
        end
      endcase
    end else begin
      dec_ileg = 1'b1;
    end
  end

  assign s2_load = !v2_q || ready_i;
  assign s1_load = !v1_q || s2_load;
  assign ready_o = s1_load && !flush_i;

  // Next-state for both pipeline stages and the illegal counter.
  always_comb begin
    v1_d     = v1_q;
    instr1_d = instr1_q;
    tag1_d   = tag1_q;
    v2_d     = v2_q;
    imm2_d   = imm2_q;
    fmt2_d   = fmt2_q;
    ileg2_d  = ileg2_q;
    tag2_d   = tag2_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
    end else begin
      if (s1_load) begin
        v1_d = valid_i;
        if (valid_i) begin
          instr1_d = instruccion_i;
          tag1_d   = tag_i;
        end else begin
          instr1_d = instr1_q;
        end
      end else begin
        v1_d = v1_q;
      end
      if (s2_load) begin
        v2_d = v1_q;
        if (v1_q) begin
          imm2_d  = dec_imm;
          fmt2_d  = dec_fmt;
          ileg2_d = dec_ileg;
          tag2_d  = tag1_q;
        end else begin
          imm2_d = imm2_q;
        end
      end else begin
        v2_d = v2_q;
      end
    end
    // an entry consumed in the same cycle as a flush was already delivered, so it counts
    if (v2_q && ready_i && ileg2_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pipeline and counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q     <= 1'b0;
      instr1_q <= 32'h0000_0000;
      tag1_q   <= '0;
      v2_q     <= 1'b0;
      imm2_q   <= '0;
      fmt2_q   <= 3'd0;
      ileg2_q  <= 1'b0;
      tag2_q   <= '0;
      cnt_q    <= '0;
    end else begin
      v1_q     <= v1_d;
      instr1_q <= instr1_d;
      tag1_q   <= tag1_d;
      v2_q     <= v2_d;
      imm2_q   <= imm2_d;
      fmt2_q   <= fmt2_d;
      ileg2_q  <= ileg2_d;
      tag2_q   <= tag2_d;
      cnt_q    <= cnt_d;
    end
  end

  assign valid_o      = v2_q;
  assign inmediato_o  = imm2_q;
  assign formato_o    = fmt2_q;
  assign ilegal_o     = ileg2_q;
  assign tag_o        = tag2_q;
  assign cnt_ilegal_o = cnt_q;

endmodule

// File: tb/tb_generador_inmediato.sv
// Directed bench for generador_inmediato: an RV32 instance (16-bit counter)
// and an RV64 instance with a 4-bit counter to reach saturation quickly.
module tb_generador_inmediato;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        flush_a, valid_a, ready_a, ready_o_a, valid_o_a, ileg_a;
  logic [31:0] instr_a, tag_a, imm_a, tago_a;
  logic [2:0]  fmt_a;
  logic [15:0] cnt_a;

  logic        flush_b, valid_b, ready_b, ready_o_b, valid_o_b, ileg_b;
  logic [31:0] instr_b;
  logic [7:0]  tag_b, tago_b;
  logic [63:0] imm_b;
  logic [2:0]  fmt_b;
  logic [3:0]  cnt_b;

  generador_inmediato #(.XLEN(32), .TAG_W(32), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush_a), .valid_i(valid_a), .ready_o(ready_o_a),
    .instruccion_i(instr_a), .tag_i(tag_a), .valid_o(valid_o_a), .ready_i(ready_a),
    .inmediato_o(imm_a), .formato_o(fmt_a), .ilegal_o(ileg_a), .tag_o(tago_a),
    .cnt_ilegal_o(cnt_a)
  );

  generador_inmediato #(.XLEN(64), .TAG_W(8), .CNT_W(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush_b), .valid_i(valid_b), .ready_o(ready_o_b),
    .instruccion_i(instr_b), .tag_i(tag_b), .valid_o(valid_o_b), .ready_i(ready_b),
    .inmediato_o(imm_b), .formato_o(fmt_b), .ilegal_o(ileg_b), .tag_o(tago_b),
    .cnt_ilegal_o(cnt_b)
  );

  int n_chk = 0;
  int n_fail = 0;
  int exp_cnt_a = 0;
  int exp_cnt_b = 0;

  logic [31:0] vi [32];
  logic [63:0] ve [32];
  logic [2:0]  vf [32];
  int nv;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic [31:0] ins, input logic [63:0] imm, input logic [2:0] fmt);
    vi[nv] = ins;
    ve[nv] = imm;
    vf[nv] = fmt;
    nv++;
  endtask

  // Streams nv vectors into dut_a at full rate; entry k appears two cycles after it is driven.
  task automatic stream_a();
    for (int k = 0; k < nv + 2; k++) begin
      ready_a = 1'b1;
      valid_a = (k < nv);
      instr_a = (k < nv) ? vi[k] : 32'h0000_0013;
      tag_a   = 32'h0000_1000 + 32'(k);
      #1;
      if (k < nv) begin
        n_chk++;
        if (ready_o_a !== 1'b1) begin
          n_fail++; $display("FAIL stream_a ready_o k=%0d got %b want 1", k, ready_o_a);
        end
      end
      n_chk++;
      if (k < 2) begin
        if (valid_o_a !== 1'b0) begin
          n_fail++; $display("FAIL stream_a idle valid_o k=%0d got %b want 0", k, valid_o_a);
        end
      end else begin
        if (valid_o_a !== 1'b1 || imm_a !== ve[k-2][31:0] || fmt_a !== vf[k-2] ||
            ileg_a !== (vf[k-2] == 3'd7) || tago_a !== 32'h0000_1000 + 32'(k-2)) begin
          n_fail++;
          $display("FAIL stream_a entry %0d got v=%b imm=%h fmt=%0d il=%b tag=%h want imm=%h fmt=%0d tag=%h",
                   k-2, valid_o_a, imm_a, fmt_a, ileg_a, tago_a, ve[k-2][31:0], vf[k-2],
                   32'h0000_1000 + 32'(k-2));
        end
      end
      n_chk++;
      if (cnt_a !== 16'(exp_cnt_a)) begin
        n_fail++; $display("FAIL stream_a cnt k=%0d got %0d want %0d", k, cnt_a, exp_cnt_a);
      end
      if (k >= 2 && vf[k-2] == 3'd7 && exp_cnt_a < 65535) exp_cnt_a++;
      cyc();
    end
    valid_a = 1'b0;
    n_chk++;
    if (cnt_a !== 16'(exp_cnt_a)) begin
      n_fail++; $display("FAIL stream_a final cnt got %0d want %0d", cnt_a, exp_cnt_a);
    end
  endtask

  task automatic stream_b();
    for (int k = 0; k < nv + 2; k++) begin
      ready_b = 1'b1;
      valid_b = (k < nv);
      instr_b = (k < nv) ? vi[k] : 32'h0000_0013;
      tag_b   = 8'(k + 1);
      #1;
      n_chk++;
      if (k < 2) begin
        if (valid_o_b !== 1'b0) begin
          n_fail++; $display("FAIL stream_b idle valid_o k=%0d got %b want 0", k, valid_o_b);
        end
      end else begin
        if (valid_o_b !== 1'b1 || imm_b !== ve[k-2] || fmt_b !== vf[k-2] ||
            ileg_b !== (vf[k-2] == 3'd7) || tago_b !== 8'(k - 1)) begin
          n_fail++;
          $display("FAIL stream_b entry %0d got v=%b imm=%h fmt=%0d il=%b tag=%h want imm=%h fmt=%0d tag=%h",
                   k-2, valid_o_b, imm_b, fmt_b, ileg_b, tago_b, ve[k-2], vf[k-2], 8'(k - 1));
        end
      end
      n_chk++;
      if (cnt_b !== 4'(exp_cnt_b)) begin
        n_fail++; $display("FAIL stream_b cnt k=%0d got %0d want %0d", k, cnt_b, exp_cnt_b);
      end
      if (k >= 2 && vf[k-2] == 3'd7 && exp_cnt_b < 15) exp_cnt_b++;
      cyc();
    end
    valid_b = 1'b0;
    n_chk++;
    if (cnt_b !== 4'(exp_cnt_b)) begin
      n_fail++; $display("FAIL stream_b final cnt got %0d want %0d", cnt_b, exp_cnt_b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    n_chk++;
    if (valid_o_a !== 1'b0 || imm_a !== 32'h0 || fmt_a !== 3'd0 || ileg_a !== 1'b0 ||
        tago_a !== 32'h0 || cnt_a !== 16'h0) begin
      n_fail++; $display("FAIL reset_a got v=%b imm=%h fmt=%0d il=%b tag=%h cnt=%h want all 0",
                         valid_o_a, imm_a, fmt_a, ileg_a, tago_a, cnt_a);
    end
    n_chk++;
    if (valid_o_b !== 1'b0 || imm_b !== 64'h0 || fmt_b !== 3'd0 || cnt_b !== 4'h0) begin
      n_fail++; $display("FAIL reset_b got v=%b imm=%h fmt=%0d cnt=%h want all 0",
                         valid_o_b, imm_b, fmt_b, cnt_b);
    end
    rst = 1'b0;
    #1;
    n_chk++;
    if (ready_o_a !== 1'b1) begin
      n_fail++; $display("FAIL reset ready_o got %b want 1", ready_o_a);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    nv = 0;
    add_vec(32'hFFF0_0093, 64'hFFFF_FFFF, 3'd0);
    add_vec(32'hFE11_2E23, 64'hFFFF_FFFC, 3'd1);
    stream_a();
  endtask

  task automatic test_formats();
    nv = 0;
    add_vec(32'hFE00_0CE3, 64'hFFFF_FFF8, 3'd2);
    add_vec(32'h0010_006F, 64'h0000_0800, 3'd4);
    add_vec(32'h1234_50B7, 64'h1234_5000, 3'd3);
    add_vec(32'h4030_D093, 64'h0000_0003, 3'd5);
    add_vec(32'h8000_2083, 64'hFFFF_F800, 3'd0);
    add_vec(32'h0020_81B3, 64'h0000_0000, 3'd6);
    add_vec(32'h0010_809B, 64'h0000_0000, 3'd7);
    add_vec(32'hFFF0_0090, 64'h0000_0000, 3'd7);
    stream_a();
  endtask

  task automatic test_illegal_count();
    nv = 0;
    for (int i = 0; i < 4; i++) add_vec(32'h0000_0000, 64'h0, 3'd7);
    stream_a();
  endtask

  task automatic test_xlen64();
    nv = 0;
    add_vec(32'hFFF0_0093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0);
    add_vec(32'h4030_D093, 64'h0000_0000_0000_0003, 3'd5);
    add_vec(32'h0200_9093, 64'h0000_0000_0000_0020, 3'd5);
    add_vec(32'h0010_809B, 64'h0000_0000_0000_0001, 3'd0);
    add_vec(32'h0030_909B, 64'h0000_0000_0000_0003, 3'd5);
    add_vec(32'h8000_00B7, 64'hFFFF_FFFF_8000_0000, 3'd3);
    add_vec(32'hFE00_0CE3, 64'hFFFF_FFFF_FFFF_FFF8, 3'd2);
    add_vec(32'h0020_803B, 64'h0000_0000_0000_0000, 3'd6);
    stream_b();
  endtask

  task automatic test_backpressure();
    logic [31:0] ins [3];
    ins[0] = 32'h0010_0093;
    ins[1] = 32'h0020_0093;
    ins[2] = 32'h0030_0093;
    ready_a = 1'b0;
    for (int c = 0; c < 9; c++) begin
      valid_a = (c < 6);
      instr_a = ins[(c < 2) ? c : 2];
      tag_a   = 32'h10 + 32'((c < 2) ? c : 2);
      if (c == 5) ready_a = 1'b1;
      #1;
      n_chk++;
      if (c < 2 && ready_o_a !== 1'b1) begin
        n_fail++; $display("FAIL backpressure ready_o c=%0d got %b want 1", c, ready_o_a);
      end else if (c >= 2 && c <= 4 && (ready_o_a !== 1'b0 || valid_o_a !== 1'b1 ||
                   imm_a !== 32'h1 || tago_a !== 32'h10)) begin
        n_fail++; $display("FAIL backpressure hold c=%0d got rdy=%b v=%b imm=%h tag=%h want 0/1/1/10",
                           c, ready_o_a, valid_o_a, imm_a, tago_a);
      end else if (c >= 5 && c <= 7 && (valid_o_a !== 1'b1 || imm_a !== 32'(c - 4) ||
                   tago_a !== 32'h10 + 32'(c - 5))) begin
        n_fail++; $display("FAIL backpressure drain c=%0d got v=%b imm=%h tag=%h want imm=%h",
                           c, valid_o_a, imm_a, tago_a, 32'(c - 4));
      end else if (c == 8 && valid_o_a !== 1'b0) begin
        n_fail++; $display("FAIL backpressure extra entry got valid_o=%b want 0", valid_o_a);
      end
      if (c == 6) valid_a = 1'b0;
      cyc();
    end
  endtask

  task automatic test_flush();
    ready_a = 1'b0;
    valid_a = 1'b1;
    instr_a = 32'h0000_0000;
    tag_a   = 32'h20;
    cyc();
    tag_a   = 32'h21;
    cyc();
    flush_a = 1'b1;
    instr_a = 32'h0050_0093;
    tag_a   = 32'h22;
    #1;
    n_chk++;
    if (ready_o_a !== 1'b0 || valid_o_a !== 1'b1) begin
      n_fail++; $display("FAIL flush cycle got ready_o=%b valid_o=%b want 0/1", ready_o_a, valid_o_a);
    end
    cyc();
    flush_a = 1'b0;
    ready_a = 1'b1;
    tag_a   = 32'h23;
    #1;
    n_chk++;
    if (valid_o_a !== 1'b0 || ready_o_a !== 1'b1) begin
      n_fail++; $display("FAIL flush after got valid_o=%b ready_o=%b want 0/1", valid_o_a, ready_o_a);
    end
    cyc();
    valid_a = 1'b0;
    n_chk++;
    if (valid_o_a !== 1'b0) begin
      n_fail++; $display("FAIL flush bubble got valid_o=%b want 0", valid_o_a);
    end
    cyc();
    n_chk++;
    if (valid_o_a !== 1'b1 || imm_a !== 32'h5 || fmt_a !== 3'd0 || tago_a !== 32'h23) begin
      n_fail++; $display("FAIL flush next entry got v=%b imm=%h fmt=%0d tag=%h want 1/5/0/23",
                         valid_o_a, imm_a, fmt_a, tago_a);
    end
    cyc();
    n_chk++;
    if (valid_o_a !== 1'b0 || cnt_a !== 16'(exp_cnt_a)) begin
      n_fail++; $display("FAIL flush tail got valid_o=%b cnt=%0d want 0/%0d", valid_o_a, cnt_a, exp_cnt_a);
    end
  endtask

  task automatic test_reset_mid();
    ready_a = 1'b1;
    valid_a = 1'b1;
    instr_a = 32'h0000_0000;
    tag_a   = 32'h30;
    cyc();
    tag_a   = 32'h31;
    cyc();
    valid_a = 1'b0;
    n_chk++;
    if (valid_o_a !== 1'b1 || ileg_a !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid pre got valid_o=%b ilegal=%b want 1/1", valid_o_a, ileg_a);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    exp_cnt_a = 0;
    exp_cnt_b = 0;
    n_chk++;
    if (valid_o_a !== 1'b0 || cnt_a !== 16'h0 || tago_a !== 32'h0 || imm_a !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid got v=%b cnt=%0d tag=%h imm=%h want 0/0/0/0",
                         valid_o_a, cnt_a, tago_a, imm_a);
    end
    cyc();
    n_chk++;
    if (valid_o_a !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid s1 drop got valid_o=%b want 0", valid_o_a);
    end
  endtask

  task automatic test_saturation();
    nv = 0;
    for (int i = 0; i < 18; i++) add_vec(32'h0000_0000, 64'h0, 3'd7);
    stream_b();
    n_chk++;
    if (cnt_b !== 4'hF) begin
      n_fail++; $display("FAIL saturation cnt got %h want f", cnt_b);
    end
  endtask

  initial begin
    rst = 1'b1;
    flush_a = 1'b0; valid_a = 1'b0; ready_a = 1'b1; instr_a = 32'h0; tag_a = 32'h0;
    flush_b = 1'b0; valid_b = 1'b0; ready_b = 1'b1; instr_b = 32'h0; tag_b = 8'h0;
    #1;
    test_reset();
    test_back_to_back();
    test_formats();
    test_illegal_count();
    test_backpressure();
    test_flush();
    test_xlen64();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
